booth_seq_ctrl: RTL and testbench
=================================

// Module: booth_seq_ctrl
// PURPOSE
//  Moore FSM that sequences the ALU multiply datapath for signed radix-2 Booth multiplication.
//  The datapath contains the shift registers A (accumulator), Q (multiplier) and Q[-1], the
//  M register, and the adder/subtractor.
//  Per operation: loads operands from inbus, runs WIDTH test/add/shift iterations, then
//  drives A then Q onto outbus. Emits only control strobes; holds no data.
// PARAMETERS
//  WIDTH   8                 operand width in bits; iteration count; must be >= 2
//  CNT_W   $clog2(WIDTH)+1   bit-counter width
// PORTS
//  clk        in   1  single clock; all state changes on rising edge
//  reset      in   1  asynchronous, active-low reset (0 = reset)
//  start      in   1  request a multiply; sampled only in IDLE
//  q0         in   1  Q[0] from the Q register
//  q_m1       in   1  Q[-1] bit
//  ld_m       out  1  M <= inbus
//  ld_q       out  1  Q <= inbus
//  clr_a      out  1  A <= 0; Q[-1] <= 0
//  ld_a       out  1  A <= adder result
//  sub        out  1  adder op: 1 = A-M, 0 = A+M; meaningful only while ld_a=1
//  shr        out  1  arithmetic right shift of {A,Q,Q[-1]}; datapath feeds A MSB back into A MSB
//  out_a      out  1  drive A onto outbus
//  out_q      out  1  drive Q onto outbus
//  busy       out  1  high in every state except IDLE
//  done       out  1  one-cycle pulse at completion
// BEHAVIOUR
//  Reset
//   - reset=0 at any time, including mid-operation, forces state=IDLE and cnt=0 immediately.
//   - All outputs are 0 while in reset.
//   - No partial result is emitted; datapath registers are not cleared by this block.
//  Output decode
//   - Outputs decode combinationally from the state register only (Moore).
//   - At most one of {ld_m, ld_q, ld_a, shr, out_a, out_q} is high in any cycle.
//  States and transitions
//   - IDLE:  outputs 0. start=1 -> LOAD_M; otherwise stay.
//   - LOAD_M: ld_m=1 -> LOAD_Q.
//   - LOAD_Q: ld_q=1, clr_a=1; cnt<=0 -> TEST.
//   - TEST:  no strobes. {q0,q_m1}=10 -> SUB; 01 -> ADD; 00 or 11 -> SHIFT.
//   - ADD:   ld_a=1, sub=0 -> SHIFT.
//   - SUB:   ld_a=1, sub=1 -> SHIFT.
//   - SHIFT: shr=1; cnt<=cnt+1. If cnt==WIDTH-1 (pre-increment) -> OUT_A; else -> TEST.
//   - OUT_A: out_a=1 -> OUT_Q.
//   - OUT_Q: out_q=1 -> DONE.
//   - DONE:  done=1 -> IDLE.
//  Latency
//   - Measured from the edge that samples start=1 in IDLE to the cycle in which done is high.
//   - Latency = 5 + 2*WIDTH + K cycles, where K = number of ADD/SUB visits.
//   - Range for WIDTH=8: 21..29 cycles.
//  Boundary conditions
//   - start while busy=1 is ignored (not queued).
//   - start held high through DONE restarts one cycle after DONE; start is sampled in IDLE.
//   - q0/q_m1 are sampled only in TEST; values in all other states are don't-care.
//   - cnt never wraps: exactly WIDTH SHIFT states per operation.
// TESTING
//  - Reset mid-op: pulse reset low during any ADD cycle -> next cycle in IDLE, all outputs 0,
//    busy=0; a new start then runs a full, correct sequence.
//  - Q=8'h00 (q0,q_m1 model stays 00), start=1 -> no ld_a ever; 8 shr pulses; done 21 cycles after start.
//  - M=3, Q=5 with a behavioural A/Q model:
//    4 ld_a pulses in order sub,add,sub,add;
//    done at cycle 25; outbus gives A=8'h00 then Q=8'h0F.
//  - M=-4 (8'hFC), Q=-3 (8'hFD) with the model -> product 12 = {A,Q} = 16'h000C.
//  - M=8'h80, Q=8'h80 with the model -> product 16'h4000 (corner: most-negative operands).
//  - start pulsed during busy -> ignored, no extra ld_m.
//  - start held high continuously -> back-to-back ops with exactly one IDLE cycle between DONE and LOAD_M.
//  - Every cycle: assert one-hot strobes; assert busy == (state != IDLE); done width exactly 1.

Source files
------------

// File: rtl/booth_seq_ctrl.sv
// Moore control FSM for a signed radix-2 Booth multiplier datapath.
// Loads M and Q, runs WIDTH test/add-sub/shift iterations, then presents A and Q.
module booth_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       q0,
  input  logic       q_m1,
  output logic       ld_m,
  output logic       ld_q,
  output logic       clr_a,
  output logic       ld_a,
  output logic       sub,
  output logic       shr,
  output logic       out_a,
  output logic       out_q,
  output logic       busy,
  output logic       done,
  output logic [3:0] state_dbg
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LOAD_M = 4'd1;
  localparam logic [3:0] S_LOAD_Q = 4'd2;
  localparam logic [3:0] S_TEST   = 4'd3;
  localparam logic [3:0] S_ADD    = 4'd4;
  localparam logic [3:0] S_SUB    = 4'd5;
  localparam logic [3:0] S_SHIFT  = 4'd6;
  localparam logic [3:0] S_OUT_A  = 4'd7;
  localparam logic [3:0] S_OUT_Q  = 4'd8;
  localparam logic [3:0] S_DONE   = 4'd9;

  logic [3:0]       state;
  logic [3:0]       state_nx;
  logic [CNT_W-1:0] cnt;
  logic             last_iter;

  // cnt is compared before its increment, so SHIFT runs exactly WIDTH times.
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == S_LOAD_Q) begin
        cnt <= '0;
      end else if (state == S_SHIFT) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_LOAD_M;
      S_LOAD_M: state_nx = S_LOAD_Q;
      S_LOAD_Q: state_nx = S_TEST;
      S_TEST: begin
        // Booth pair {Q[0],Q[-1]}: 10 subtracts M, 01 adds M, otherwise shift only.
        case ({q0, q_m1})
          2'b10:   state_nx = S_SUB;
          2'b01:   state_nx = S_ADD;
          default: state_nx = S_SHIFT;
        endcase
      end
      S_ADD:    state_nx = S_SHIFT;
      S_SUB:    state_nx = S_SHIFT;
      S_SHIFT:  state_nx = last_iter ? S_OUT_A : S_TEST;
      S_OUT_A:  state_nx = S_OUT_Q;
      S_OUT_Q:  state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    ld_m  = 1'b0;
    ld_q  = 1'b0;
    clr_a = 1'b0;
    ld_a  = 1'b0;
    sub   = 1'b0;
    shr   = 1'b0;
    out_a = 1'b0;
    out_q = 1'b0;
    done  = 1'b0;
    busy  = (state != S_IDLE);
    case (state)
      S_LOAD_M: ld_m = 1'b1;
      S_LOAD_Q: begin
        ld_q  = 1'b1;
        clr_a = 1'b1;
      end
      S_ADD:    ld_a = 1'b1;
      S_SUB: begin
        ld_a = 1'b1;
        sub  = 1'b1;
      end
      S_SHIFT:  shr   = 1'b1;
      S_OUT_A:  out_a = 1'b1;
      S_OUT_Q:  out_q = 1'b1;
      S_DONE:   done  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed bench for booth_seq_ctrl: a behavioural A/Q/M datapath follows the strobes,
// and every scenario checks latency, strobe counts, add/sub order and the product.
module tb_booth_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       q0, q_m1;
  logic       ld_m, ld_q, clr_a, ld_a, sub, shr, out_a, out_q, busy, done;
  logic [3:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] op_m, op_q;
  logic [8:0] a_reg = '0;  // extra guard bit keeps M = -128 from overflowing A
  logic [7:0] m_reg = '0;
  logic [7:0] q_reg = '0;
  logic       qm1_reg = 1'b0;
  logic       done_prev = 1'b0;

  logic [0:0] exp_q[$];
  logic [0:0] got_q[$];

  booth_seq_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .q0(q0), .q_m1(q_m1),
    .ld_m(ld_m), .ld_q(ld_q), .clr_a(clr_a), .ld_a(ld_a), .sub(sub), .shr(shr),
    .out_a(out_a), .out_q(out_q), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // behavioural datapath
  assign q0   = q_reg[0];
  assign q_m1 = qm1_reg;

  always @(posedge clk) begin
    if (ld_m) m_reg <= op_m;
    if (ld_q) q_reg <= op_q;
    if (clr_a) begin
      a_reg   <= '0;
      qm1_reg <= 1'b0;
    end
    if (ld_a) a_reg <= sub ? a_reg - {m_reg[7], m_reg} : a_reg + {m_reg[7], m_reg};
    if (shr) begin
      a_reg   <= {a_reg[8], a_reg[8:1]};
      q_reg   <= {a_reg[0], q_reg[7:1]};
      qm1_reg <= q_reg[0];
    end
  end

  // per-cycle protocol monitor
  always @(negedge clk) begin
    if (!reset) begin
      done_prev = 1'b0;
    end else begin
      n_checks++;
      if ($countones({ld_m, ld_q, ld_a, shr, out_a, out_q}) > 1) begin
        n_fail++;
        $display("FAIL onehot: strobes=%b required at most one high", {ld_m, ld_q, ld_a, shr, out_a, out_q});
      end
      n_checks++;
      if (busy !== (state_dbg != 4'd0)) begin
        n_fail++;
        $display("FAIL busy_vs_state: busy=%b state=%0d", busy, state_dbg);
      end
      n_checks++;
      if (clr_a !== ld_q) begin
        n_fail++;
        $display("FAIL clr_a_with_ld_q: clr_a=%b required %b", clr_a, ld_q);
      end
      if (done) begin
        n_checks++;
        if (done_prev) begin
          n_fail++;
          $display("FAIL done_width: done high for 2+ cycles, required 1");
        end
      end
      done_prev = done;
    end
  end

  // driver: one full operation; optional extra start pulse at cycle pulse_at
  task automatic run_op(input logic [7:0] m, input logic [7:0] q, input int pulse_at,
                        output int lat, output int n_lda, output int n_shr, output int n_ldm,
                        output logic [15:0] prod);
    lat = -1; n_lda = 0; n_shr = 0; n_ldm = 0; prod = '0;
    got_q.delete();
    op_m = m;
    op_q = q;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      start = (cyc == pulse_at);
      if (ld_m) n_ldm++;
      if (ld_a) begin
        n_lda++;
        got_q.push_back(sub);
      end
      if (shr) n_shr++;
      if (out_a) prod[15:8] = a_reg[7:0];
      if (out_q) prod[7:0] = q_reg;
      if (done) begin
        lat = cyc;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_subs(input string name);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_sub_count: got %0d ld_a pulses, required %0d", name, got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL %s_sub_order[%0d]: sub=%b required %b", name, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic check_op(input string name, input int lat, input int exp_lat,
                          input int n_lda, input int exp_lda, input int n_shr,
                          input logic [15:0] prod, input logic [15:0] exp_prod);
    n_checks++;
    if (lat !== exp_lat) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d required %0d", name, lat, exp_lat);
    end
    n_checks++;
    if (n_lda !== exp_lda) begin
      n_fail++;
      $display("FAIL %s_ld_a_count: got %0d required %0d", name, n_lda, exp_lda);
    end
    n_checks++;
    if (n_shr !== 8) begin
      n_fail++;
      $display("FAIL %s_shr_count: got %0d required 8", name, n_shr);
    end
    n_checks++;
    if (prod !== exp_prod) begin
      n_fail++;
      $display("FAIL %s_product: got %h required %h", name, prod, exp_prod);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ld_m, ld_q, clr_a, ld_a, sub, shr, out_a, out_q, busy, done} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 0",
               {ld_m, ld_q, clr_a, ld_a, sub, shr, out_a, out_q, busy, done});
    end
    n_checks++;
    if (state_dbg !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d required 0", state_dbg);
    end
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b required 0", busy);
    end
  endtask

  task automatic test_zero_multiplier;
    int lat, n_lda, n_shr, n_ldm;
    logic [15:0] prod;
    exp_q.delete();
    run_op(8'h05, 8'h00, 0, lat, n_lda, n_shr, n_ldm, prod);
    check_op("zero_q", lat, 21, n_lda, 0, n_shr, prod, 16'h0000);
    check_subs("zero_q");
  endtask

  task automatic test_m3_q5;
    int lat, n_lda, n_shr, n_ldm;
    logic [15:0] prod;
    exp_q.delete();
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    run_op(8'd3, 8'd5, 0, lat, n_lda, n_shr, n_ldm, prod);
    check_op("m3_q5", lat, 25, n_lda, 4, n_shr, prod, 16'h000F);
    check_subs("m3_q5");
  endtask

  task automatic test_negative;
    int lat, n_lda, n_shr, n_ldm;
    logic [15:0] prod;
    exp_q.delete();
    exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    run_op(8'hFC, 8'hFD, 0, lat, n_lda, n_shr, n_ldm, prod);
    check_op("neg", lat, 24, n_lda, 3, n_shr, prod, 16'h000C);
    check_subs("neg");
  endtask

  task automatic test_most_negative;
    int lat, n_lda, n_shr, n_ldm;
    logic [15:0] prod;
    exp_q.delete();
    exp_q.push_back(1'b1);
    run_op(8'h80, 8'h80, 0, lat, n_lda, n_shr, n_ldm, prod);
    check_op("most_neg", lat, 22, n_lda, 1, n_shr, prod, 16'h4000);
    check_subs("most_neg");
  endtask

  task automatic test_start_while_busy;
    int lat, n_lda, n_shr, n_ldm;
    logic [15:0] prod;
    run_op(8'h05, 8'h00, 6, lat, n_lda, n_shr, n_ldm, prod);
    check_op("busy_start", lat, 21, n_lda, 0, n_shr, prod, 16'h0000);
    n_checks++;
    if (n_ldm !== 1) begin
      n_fail++;
      $display("FAIL busy_start_ld_m: got %0d ld_m pulses required 1", n_ldm);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start_not_queued: busy=%b required 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    int done1, done2, ldm2, idle_busy;
    done1 = -1; done2 = -1; ldm2 = -1; idle_busy = -1;
    op_m = 8'd3;
    op_q = 8'd5;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(negedge clk);
      if (done1 > 0 && cyc == done1 + 1) idle_busy = busy;
      if (done1 > 0 && ldm2 < 0 && ld_m) begin
        ldm2  = cyc;
        start = 1'b0;
      end
      if (done) begin
        if (done1 < 0) done1 = cyc;
        else begin
          done2 = cyc;
          break;
        end
      end
    end
    start = 1'b0;
    n_checks++;
    if (done1 !== 25) begin
      n_fail++;
      $display("FAIL b2b_done1: cycle %0d required 25", done1);
    end
    n_checks++;
    if (idle_busy !== 0) begin
      n_fail++;
      $display("FAIL b2b_idle_gap: busy=%0d in cycle after done, required 0", idle_busy);
    end
    n_checks++;
    if (ldm2 !== 27) begin
      n_fail++;
      $display("FAIL b2b_restart: second ld_m at cycle %0d required 27", ldm2);
    end
    n_checks++;
    if (done2 !== 51) begin
      n_fail++;
      $display("FAIL b2b_done2: cycle %0d required 51", done2);
    end
  endtask

  task automatic test_reset_mid_op;
    int lat, n_lda, n_shr, n_ldm;
    logic [15:0] prod;
    bit found;
    found = 1'b0;
    op_m = 8'd3;
    op_q = 8'd5;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (ld_a && !sub) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL reset_mid_find_add: no ADD cycle seen within 40 cycles");
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({ld_m, ld_q, clr_a, ld_a, sub, shr, out_a, out_q, busy, done} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %b required 0",
               {ld_m, ld_q, clr_a, ld_a, sub, shr, out_a, out_q, busy, done});
    end
    n_checks++;
    if (state_dbg !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mid_state: got %0d required 0", state_dbg);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_q.delete();
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    run_op(8'd3, 8'd5, 0, lat, n_lda, n_shr, n_ldm, prod);
    check_op("after_reset", lat, 25, n_lda, 4, n_shr, prod, 16'h000F);
    check_subs("after_reset");
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    op_m  = '0;
    op_q  = '0;
    test_reset;
    test_zero_multiplier;
    test_m3_q5;
    test_negative;
    test_most_negative;
    test_start_while_busy;
    test_back_to_back;
    repeat (2) @(negedge clk);
    test_reset_mid_op;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
